ysyx_22050499_ifu: RTL and testbench
====================================

Name: ysyx_22050499_ifu

Overview:
- Instruction fetch unit: the producer side of the instruction word that decode and the immediate extender consume.
- Holds the PC and fetches one 32-bit instruction at a time from instruction memory over a req/gnt + rvalid interface.
- Presents the instruction to decode over a valid/ready handshake.
- Accepts PC redirects (branch/jump/trap) from execute; fetches for a stale PC are squashed.

Parameters:
- RESET_PC, 32'h8000_0000, PC loaded on reset.
- XLEN, 32, width of PC, address and instruction.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- halt  in  1  when high, no new memory request is started; an outstanding request still completes.
- mem_req  out  1  fetch request.
- mem_addr  out  XLEN  fetch address, equals PC while mem_req is high.
- mem_gnt  in  1  request accepted this cycle (mem_req && mem_gnt).
- mem_rvalid  in  1  response valid; arrives at least 1 cycle after grant.
- mem_rdata  in  XLEN  instruction word.
- mem_rerr  in  1  access fault with the response.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode accepts.
- inst  out  XLEN  instruction word.
- inst_pc  out  XLEN  PC of inst.
- inst_err  out  1  fetch fault flag for inst.
- redirect_valid  in  1  PC redirect this cycle.
- redirect_pc  in  XLEN  new PC; bits [1:0] are forced to 0 when loaded.

Behaviour:
- Reset (async, active-high):
  - pc = RESET_PC; state = IDLE; drop = 0.
  - mem_req = 0, mem_addr = RESET_PC, inst_valid = 0, inst = 0, inst_pc = 0, inst_err = 0.
  - Reset mid-operation abandons all in-flight state.
  - A mem_rvalid arriving after reset with nothing outstanding is ignored.
- All outputs are registered or derived from state only; there is no combinational path from any input to any output.
- States:
  - IDLE: mem_req = 0. If !halt, go to REQ next cycle.
  - REQ: mem_req = 1, mem_addr = pc. On mem_gnt, go to WAIT.
    - mem_addr may change before grant (redirect); the memory side samples it only on grant.
  - WAIT: on mem_rvalid:
    - If drop = 1: discard the response, clear drop, go to REQ, or to IDLE if halt.
    - Otherwise: capture inst = mem_rdata, inst_pc = pc, inst_err = mem_rerr, and go to HOLD.
  - HOLD: inst_valid = 1; inst, inst_pc and inst_err are stable until the handshake.
    - On inst_valid && inst_ready: pc = pc + 4 (mod 2^32 wrap), go to REQ, or to IDLE if halt.
- Redirect (redirect_valid high), in any non-reset state, pc = {redirect_pc[31:2], 2'b00} next cycle:
  - IDLE: pc updated, state unchanged.
  - REQ without mem_gnt: stay in REQ; next cycle mem_addr shows the new PC.
  - REQ with mem_gnt in the same cycle: go to WAIT with drop = 1; the granted fetch was for the old PC.
  - WAIT without rvalid: drop = 1.
  - WAIT with rvalid in the same cycle: the response is discarded; go to REQ, or IDLE if halt.
  - HOLD: the held instruction is discarded even if inst_ready is high in the same cycle (no pc + 4); inst_valid = 0 next cycle; go to REQ, or IDLE if halt.
  - Redirect always beats a same-cycle handshake or response.
- Latency:
  - Zero-wait memory (gnt in the same cycle, rvalid the next): request cycle N, response N+1, inst_valid at N+2.
  - Best throughput is one instruction per 3 cycles.
- At most one outstanding request.
- mem_rvalid outside WAIT is ignored.
- inst_err is passed through to decode; the IFU takes no trap action itself.

Test Plan:
- Reset release, zero-wait memory returning 32'h0000_0413 for 0x8000_0000:
  - mem_req/mem_addr = 0x8000_0000 one cycle after reset release.
  - Then inst_valid with inst = 0x0000_0413, inst_pc = 0x8000_0000.
  - After inst_ready, the next mem_addr = 0x8000_0004.
- Backpressure: hold inst_ready = 0 for 5 cycles in HOLD -> inst/inst_pc stable, mem_req = 0 throughout; handshake on cycle 6 -> pc advances by exactly 4.
- Redirect in WAIT to 0x8000_0100, with the old response arriving 2 cycles later -> that response is never presented; the next fetch is at 0x8000_0100, and its inst_pc = 0x8000_0100.
- Redirect to 0x8000_0203 in HOLD in the same cycle as inst_ready = 1 -> held instruction dropped, no pc + 4, next mem_addr = 0x8000_0200.
- mem_rerr = 1 on a response -> inst_valid with inst_err = 1; after the handshake, the next fetch carries inst_err = 0.
- Further cases, each one line:
  - pc = 0xFFFF_FFFC handshake -> next mem_addr = 0x0000_0000.
  - halt = 1 in WAIT -> the response is still delivered, then the IFU stays in IDLE with no mem_req until halt = 0.
  - rst pulse while in WAIT -> all outputs return to reset values immediately; a stray rvalid afterwards produces no inst_valid.

Source files
------------

// File: rtl/ysyx_22050499_ifu.sv
// Instruction fetch unit: owns the PC, issues one req/gnt+rvalid fetch at a time
// and holds the fetched word for decode until it is accepted or redirected away.
module ysyx_22050499_ifu #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            halt,
   output logic            mem_req,
   output logic [XLEN-1:0] mem_addr,
   input  logic            mem_gnt,
   input  logic            mem_rvalid,
   input  logic [XLEN-1:0] mem_rdata,
   input  logic            mem_rerr,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] inst,
   output logic [XLEN-1:0] inst_pc,
   output logic            inst_err,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_HOLD = 2'd3;

   logic [1:0]      state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            drop_q, drop_d;
   logic [XLEN-1:0] inst_q, inst_d;
   logic [XLEN-1:0] inst_pc_q, inst_pc_d;
   logic            inst_err_q, inst_err_d;
   logic [1:0]      next_fetch;
   logic            unused_rpc_lo;

   assign unused_rpc_lo = ^redirect_pc[1:0];
   // After a delivered or discarded fetch, either fetch again or park while halted.
   assign next_fetch    = halt ? S_IDLE : S_REQ;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      drop_d     = drop_q;
      inst_d     = inst_q;
      inst_pc_d  = inst_pc_q;
      inst_err_d = inst_err_q;
      case (state_q)
         S_IDLE: if (!halt) state_d = S_REQ;
         S_REQ: begin
            if (mem_gnt) begin
               state_d = S_WAIT;
               drop_d  = redirect_valid;
            end
         end
         S_WAIT: begin
            if (mem_rvalid) begin
               drop_d = 1'b0;
               if (drop_q || redirect_valid) begin
                  state_d = next_fetch;
               end else begin
                  inst_d     = mem_rdata;
                  inst_pc_d  = pc_q;
                  inst_err_d = mem_rerr;
                  state_d    = S_HOLD;
               end
            end else if (redirect_valid) begin
               drop_d = 1'b1;
            end
         end
         default: begin
            if (redirect_valid || inst_ready) state_d = next_fetch;
            if (!redirect_valid && inst_ready) pc_d = pc_q + XLEN'(4);
         end
      endcase
      // A redirect wins over any same-cycle handshake or response.
      if (redirect_valid) pc_d = {redirect_pc[XLEN-1:2], 2'b00};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         drop_q     <= 1'b0;
         inst_q     <= '0;
         inst_pc_q  <= '0;
         inst_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         drop_q     <= drop_d;
         inst_q     <= inst_d;
         inst_pc_q  <= inst_pc_d;
         inst_err_q <= inst_err_d;
      end
   end

   assign mem_req    = (state_q == S_REQ);
   assign mem_addr   = pc_q;
   assign inst_valid = (state_q == S_HOLD);
   assign inst       = inst_q;
   assign inst_pc    = inst_pc_q;
   assign inst_err   = inst_err_q;

endmodule

// File: tb/tb_ysyx_22050499_ifu.sv
// Bench for the fetch unit: a latency-configurable memory responder, a PC-level
// reference model, directed scenario tasks and a randomized run.
module tb_ysyx_22050499_ifu;

   localparam logic [31:0] RESET_PC = 32'h8000_0000;

   logic        clk, rst, halt;
   logic        mem_req, mem_gnt, mem_rvalid, mem_rerr;
   logic [31:0] mem_addr, mem_rdata;
   logic        inst_valid, inst_ready, inst_err;
   logic [31:0] inst, inst_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   int vectors = 0;
   int miscompares = 0;

   ysyx_22050499_ifu #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst), .halt(halt),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rerr(mem_rerr),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
      .inst_pc(inst_pc), .inst_err(inst_err),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory contents and fault map as pure functions of the word address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h8000_0000) return 32'h0000_0413;
      return {a[15:0], a[31:16]} ^ 32'hA5C3_0013;
   endfunction

   function automatic logic mem_err(input logic [31:0] a);
      return a[11:2] == 10'h3FF;
   endfunction

   // Memory responder: grant after gnt_lat request cycles, respond rsp_lat cycles later.
   int          gnt_lat = 0, rsp_lat = 1, req_age = 0, cnt = 0;
   bit          pend = 0, mem_en = 1, rand_lat = 0;
   logic [31:0] paddr;

   initial begin
      mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; mem_rerr = 0; paddr = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            pend = 0; req_age = 0;
            if (mem_en) begin mem_gnt = 0; mem_rvalid = 0; end
         end else if (mem_en) begin
            mem_gnt = 0; mem_rvalid = 0; mem_rdata = $urandom; mem_rerr = 1'($urandom_range(0, 1));
            if (pend) begin
               cnt--;
               if (cnt == 0) begin
                  mem_rvalid = 1; mem_rdata = mem_word(paddr); mem_rerr = mem_err(paddr); pend = 0;
               end
            end else if (mem_req) begin
               if (req_age >= gnt_lat) begin
                  mem_gnt = 1; pend = 1; cnt = rsp_lat; paddr = mem_addr; req_age = 0;
                  if (rand_lat) begin
                     gnt_lat = $urandom_range(0, 3);
                     rsp_lat = $urandom_range(1, 4);
                  end
               end else req_age++;
            end
         end
      end
   end

   // Reference PC: where fetch must currently point / which PC the held word belongs to.
   logic [31:0] m_pc;
   always @(posedge clk or posedge rst) begin
      if (rst) m_pc <= RESET_PC;
      else if (redirect_valid) m_pc <= {redirect_pc[31:2], 2'b00};
      else if (inst_valid && inst_ready) m_pc <= m_pc + 32'd4;
   end

   task automatic step();
      @(negedge clk); #1;
   endtask

   task automatic handshake();
      inst_ready = 1; step(); inst_ready = 0;
   endtask

   task automatic redirect(input logic [31:0] p);
      redirect_valid = 1; redirect_pc = p; step(); redirect_valid = 0;
   endtask

   task automatic wait_valid(input int max, output bit ok);
      ok = inst_valid;
      for (int i = 0; i < max && !ok; i++) begin step(); ok = inst_valid; end
   endtask

   task automatic wait_gnt(input int max, output bit ok);
      ok = mem_gnt;
      for (int i = 0; i < max && !ok; i++) begin step(); ok = mem_gnt; end
   endtask

   task automatic test_reset();
      rst = 1; step(); step();
      vectors++;
      if ({mem_req, inst_valid, inst_err} !== 3'b000 || mem_addr !== RESET_PC) begin
         miscompares++;
         $display("FAIL reset_ctrl: req=%b valid=%b err=%b addr=%h, want 0 0 0 %h", mem_req, inst_valid, inst_err, mem_addr, RESET_PC);
      end
      vectors++;
      if (inst !== 32'h0 || inst_pc !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_inst: inst=%h inst_pc=%h, want 0 0", inst, inst_pc);
      end
      rst = 0; step();
      vectors++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h8000_0000) begin
         miscompares++;
         $display("FAIL first_req: req=%b addr=%h, want 1 80000000", mem_req, mem_addr);
      end
      step();
      vectors++;
      if (inst_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL latency_early: inst_valid=%b one cycle after request, want 0", inst_valid);
      end
      step();
      vectors++;
      if (inst_valid !== 1'b1 || inst !== 32'h0000_0413 || inst_pc !== 32'h8000_0000 || inst_err !== 1'b0) begin
         miscompares++;
         $display("FAIL first_inst: valid=%b inst=%h pc=%h err=%b, want 1 00000413 80000000 0", inst_valid, inst, inst_pc, inst_err);
      end
   endtask

   task automatic test_basic();
      handshake();
      vectors++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h8000_0004) begin
         miscompares++;
         $display("FAIL next_addr: req=%b addr=%h, want 1 80000004", mem_req, mem_addr);
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      logic [31:0] h_inst, h_pc;
      wait_valid(20, ok);
      h_inst = inst; h_pc = inst_pc;
      vectors++;
      if (!ok || h_pc !== 32'h8000_0004 || h_inst !== mem_word(32'h8000_0004)) begin
         miscompares++;
         $display("FAIL bp_inst: ok=%b pc=%h inst=%h, want 1 80000004 %h", ok, h_pc, h_inst, mem_word(32'h8000_0004));
      end
      for (int i = 0; i < 5; i++) begin
         vectors++;
         if (inst_valid !== 1'b1 || inst !== h_inst || inst_pc !== h_pc || mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_hold%0d: valid=%b inst=%h pc=%h req=%b, want 1 %h %h 0", i, inst_valid, inst, inst_pc, mem_req, h_inst, h_pc);
         end
         step();
      end
      handshake();
      vectors++;
      if (mem_req !== 1'b1 || mem_addr !== h_pc + 32'd4) begin
         miscompares++;
         $display("FAIL bp_advance: req=%b addr=%h, want 1 %h", mem_req, mem_addr, h_pc + 32'd4);
      end
   endtask

   task automatic test_redirect_wait();
      bit ok;
      rsp_lat = 3;
      wait_gnt(20, ok);
      step();
      redirect(32'h8000_0100);
      rsp_lat = 1;
      wait_valid(30, ok);
      vectors++;
      if (!ok || inst_pc !== 32'h8000_0100 || inst !== mem_word(32'h8000_0100)) begin
         miscompares++;
         $display("FAIL redir_wait: ok=%b pc=%h inst=%h, want 1 80000100 %h", ok, inst_pc, inst, mem_word(32'h8000_0100));
      end
   endtask

   task automatic test_redirect_hold();
      inst_ready = 1;
      redirect(32'h8000_0203);
      inst_ready = 0;
      vectors++;
      if (inst_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h8000_0200) begin
         miscompares++;
         $display("FAIL redir_hold: valid=%b req=%b addr=%h, want 0 1 80000200", inst_valid, mem_req, mem_addr);
      end
   endtask

   task automatic test_rerr();
      bit ok;
      wait_valid(20, ok);
      redirect(32'h8000_0FFC);
      wait_valid(20, ok);
      vectors++;
      if (!ok || inst_pc !== 32'h8000_0FFC || inst_err !== 1'b1) begin
         miscompares++;
         $display("FAIL rerr_set: ok=%b pc=%h err=%b, want 1 80000ffc 1", ok, inst_pc, inst_err);
      end
      handshake();
      wait_valid(20, ok);
      vectors++;
      if (!ok || inst_pc !== 32'h8000_1000 || inst_err !== 1'b0) begin
         miscompares++;
         $display("FAIL rerr_clear: ok=%b pc=%h err=%b, want 1 80001000 0", ok, inst_pc, inst_err);
      end
   endtask

   task automatic test_wrap();
      bit ok;
      redirect(32'hFFFF_FFFC);
      wait_valid(20, ok);
      vectors++;
      if (!ok || inst_pc !== 32'hFFFF_FFFC) begin
         miscompares++;
         $display("FAIL wrap_inst: ok=%b pc=%h, want 1 fffffffc", ok, inst_pc);
      end
      handshake();
      vectors++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
         miscompares++;
         $display("FAIL wrap_addr: req=%b addr=%h, want 1 00000000", mem_req, mem_addr);
      end
   endtask

   task automatic test_halt();
      bit ok;
      wait_gnt(20, ok);
      step();
      halt = 1;
      wait_valid(20, ok);
      vectors++;
      if (!ok || inst_pc !== 32'h0 || inst !== mem_word(32'h0)) begin
         miscompares++;
         $display("FAIL halt_deliver: ok=%b pc=%h inst=%h, want 1 00000000 %h", ok, inst_pc, inst, mem_word(32'h0));
      end
      handshake();
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (mem_req !== 1'b0 || inst_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_idle%0d: req=%b valid=%b, want 0 0", i, mem_req, inst_valid);
         end
         step();
      end
      halt = 0; step();
      vectors++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h4) begin
         miscompares++;
         $display("FAIL halt_resume: req=%b addr=%h, want 1 00000004", mem_req, mem_addr);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      rsp_lat = 3;
      wait_gnt(20, ok);
      step();
      mem_en = 0; mem_gnt = 0; mem_rvalid = 0; rsp_lat = 1;
      rst = 1; #1;
      vectors++;
      if ({mem_req, inst_valid, inst_err} !== 3'b000 || mem_addr !== RESET_PC || inst !== 32'h0 || inst_pc !== 32'h0) begin
         miscompares++;
         $display("FAIL rst_mid: req=%b valid=%b err=%b addr=%h inst=%h pc=%h, want 0 0 0 %h 0 0", mem_req, inst_valid, inst_err, mem_addr, inst, inst_pc, RESET_PC);
      end
      halt = 1; step();
      rst = 0; mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
      step(); step();
      mem_rvalid = 0;
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (inst_valid !== 1'b0 || mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL stray_rvalid%0d: valid=%b req=%b, want 0 0", i, inst_valid, mem_req);
         end
         step();
      end
      halt = 0; mem_en = 1;
      wait_valid(20, ok);
      vectors++;
      if (!ok || inst_pc !== RESET_PC || inst !== 32'h0000_0413) begin
         miscompares++;
         $display("FAIL rst_refetch: ok=%b pc=%h inst=%h, want 1 %h 00000413", ok, inst_pc, inst, RESET_PC);
      end
      handshake();
   endtask

   task automatic test_random();
      int delivered = 0;
      rand_lat = 1;
      for (int i = 0; i < 3000; i++) begin
         if (mem_req) begin
            vectors++;
            if (mem_addr !== m_pc) begin
               miscompares++;
               $display("FAIL rnd_addr@%0d: addr=%h, want %h", i, mem_addr, m_pc);
            end
         end
         if (inst_valid) begin
            vectors++;
            if (inst_pc !== m_pc || inst !== mem_word(m_pc) || inst_err !== mem_err(m_pc)) begin
               miscompares++;
               $display("FAIL rnd_inst@%0d: pc=%h inst=%h err=%b, want %h %h %b", i, inst_pc, inst, inst_err, m_pc, mem_word(m_pc), mem_err(m_pc));
            end
         end
         inst_ready     = 1'($urandom_range(0, 1));
         redirect_valid = ($urandom_range(0, 15) == 0);
         redirect_pc    = ($urandom_range(0, 3) == 0) ? $urandom : (32'h8000_0000 | ($urandom & 32'h0000_1FFF));
         halt           = ($urandom_range(0, 9) == 0);
         if (inst_valid && inst_ready && !redirect_valid) delivered++;
         step();
      end
      redirect_valid = 0; inst_ready = 0; halt = 0;
      rand_lat = 0; gnt_lat = 0; rsp_lat = 1;
      vectors++;
      if (delivered < 50) begin
         miscompares++;
         $display("FAIL rnd_progress: delivered=%0d, want >= 50", delivered);
      end
   endtask

   initial begin
      rst = 1; halt = 0; inst_ready = 0; redirect_valid = 0; redirect_pc = 0;
      test_reset();
      test_basic();
      test_backpressure();
      test_redirect_wait();
      test_redirect_hold();
      test_rerr();
      test_wrap();
      test_halt();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
